// File: rtl/hilo_unit_pkg.sv
// Shared definitions for the HI/LO unit: operand/data width, multiply/divide
// opcode encodings, FSM state encodings and small opcode decode helpers.
package hilo_unit_pkg;

    localparam int DATA_BUS = 32;

    localparam logic [1:0] MD_OP_MULT  = 2'b00;
    localparam logic [1:0] MD_OP_MULTU = 2'b01;
    localparam logic [1:0] MD_OP_DIV   = 2'b10;
    localparam logic [1:0] MD_OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_SIGN = 2'b11
    } hilo_state_e;

    // True for the two divide opcodes
    function automatic logic md_is_div(input logic [1:0] op);
        return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
    endfunction

    // True for the signed opcodes (operands are two's complement)
    function automatic logic md_is_signed(input logic [1:0] op);
        logic res;
        case (op)
            MD_OP_MULT, MD_OP_DIV:   res = 1'b1;
            MD_OP_MULTU, MD_OP_DIVU: res = 1'b0;
            default:                 res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/hilo_divider.sv
// Iterative restoring divider core for the HI/LO unit. Works on unsigned
// magnitudes: one quotient bit per clock, DIV_CYCLES clocks per divide.
// 'done' is high during the cycle whose edge writes the final step, so the
// quotient/remainder outputs are valid from the following cycle onwards.
module hilo_divider
    import hilo_unit_pkg::*;
#(
    parameter int DATA_W     = DATA_BUS,
    parameter int DIV_CYCLES = DATA_BUS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cancel,
    input  logic              start,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder,
    output logic              done
);

    localparam int CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

    logic [DATA_W-1:0] quo_r;
    logic [DATA_W-1:0] rem_r;
    logic [DATA_W-1:0] dvs_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              busy_r;

    logic [DATA_W:0]   rem_shift_s;
    logic [DATA_W:0]   diff_s;
    logic [DATA_W-1:0] rem_nxt_s;
    logic [DATA_W-1:0] quo_nxt_s;

    // One restoring step: shift in the next dividend bit, subtract if it fits
    always_comb begin
        rem_shift_s = {rem_r, quo_r[DATA_W-1]};
        diff_s      = rem_shift_s - {1'b0, dvs_r};
        rem_nxt_s   = rem_shift_s[DATA_W-1:0];
        quo_nxt_s   = {quo_r[DATA_W-2:0], 1'b0};
        if (diff_s[DATA_W] == 1'b0) begin
            rem_nxt_s = diff_s[DATA_W-1:0];
            quo_nxt_s = {quo_r[DATA_W-2:0], 1'b1};
        end else begin
            rem_nxt_s = rem_shift_s[DATA_W-1:0];
            quo_nxt_s = {quo_r[DATA_W-2:0], 1'b0};
        end
    end

    // Divider state: load on start, iterate while busy, abort on cancel
    always_ff @(posedge clk) begin
        if (!rst) begin
            quo_r  <= {DATA_W{1'b0}};
            rem_r  <= {DATA_W{1'b0}};
            dvs_r  <= {DATA_W{1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
            busy_r <= 1'b0;
        end else if (cancel) begin
            busy_r <= 1'b0;
            cnt_r  <= {CNT_W{1'b0}};
        end else if (start) begin
            quo_r  <= dividend;
            rem_r  <= {DATA_W{1'b0}};
            dvs_r  <= divisor;
            cnt_r  <= {CNT_W{1'b0}};
            busy_r <= 1'b1;
        end else if (busy_r) begin
            quo_r <= quo_nxt_s;
            rem_r <= rem_nxt_s;
            cnt_r <= cnt_r + CNT_W'(1);
            if (cnt_r == CNT_LAST) begin
                busy_r <= 1'b0;
            end
        end
    end

    assign quotient  = quo_r;
    assign remainder = rem_r;
    assign done      = busy_r && (cnt_r == CNT_LAST);

endmodule

// File: rtl/hilo_unit.sv
// HI/LO register file with multi-cycle multiply/divide engine beside EX.
// Direct MTHI/MTLO-style writes come in on hilo_write_en; MULT/MULTU/DIV/DIVU
// run through IDLE -> MUL|DIV -> SIGN and commit to HI/LO on the SIGN edge.
// Optional build macro HILO_READ_BYPASS_EN: when defined, hi_out/lo_out
// forward this cycle's commit or direct-write data; otherwise they are the
// plain HI/LO registers.
module hilo_unit
    import hilo_unit_pkg::*;
#(
    parameter int DATA_W     = DATA_BUS,
    parameter int DIV_CYCLES = DATA_BUS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hilo_write_en,
    input  logic [DATA_W-1:0] hi_in,
    input  logic [DATA_W-1:0] lo_in,
    input  logic              md_start,
    input  logic [1:0]        md_op,
    input  logic [DATA_W-1:0] md_operand_1,
    input  logic [DATA_W-1:0] md_operand_2,
    input  logic              md_cancel,
    output logic              stall_req,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out
);

    hilo_state_e state_r;
    hilo_state_e state_nxt_s;

    logic [DATA_W-1:0]   hi_r;
    logic [DATA_W-1:0]   lo_r;
    logic [DATA_W-1:0]   mag1_r;
    logic [DATA_W-1:0]   mag2_r;
    logic [DATA_W-1:0]   res_hi_r;
    logic [DATA_W-1:0]   res_lo_r;
    logic                neg_q_r;
    logic                neg_r_r;
    logic                src_div_r;

    logic                sign1_s;
    logic                sign2_s;
    logic [DATA_W-1:0]   mag1_s;
    logic [DATA_W-1:0]   mag2_s;
    logic                accept_s;
    logic                div_zero_s;
    logic                div_start_s;
    logic [2*DATA_W-1:0] product_s;
    logic [2*DATA_W-1:0] prod_mag_s;
    logic [2*DATA_W-1:0] prod_fix_s;
    logic                commit_en_s;
    logic [DATA_W-1:0]   commit_hi_s;
    logic [DATA_W-1:0]   commit_lo_s;
    logic [DATA_W-1:0]   div_quo_s;
    logic [DATA_W-1:0]   div_rem_s;
    logic                div_done_s;

    // Operand sign/magnitude extraction and start qualification
    always_comb begin
        sign1_s    = md_is_signed(md_op) & md_operand_1[DATA_W-1];
        sign2_s    = md_is_signed(md_op) & md_operand_2[DATA_W-1];
        mag1_s     = md_operand_1;
        mag2_s     = md_operand_2;
        if (sign1_s) begin
            mag1_s = -md_operand_1;
        end else begin
            mag1_s = md_operand_1;
        end
        if (sign2_s) begin
            mag2_s = -md_operand_2;
        end else begin
            mag2_s = md_operand_2;
        end
        accept_s    = (state_r == ST_IDLE) && md_start && !md_cancel;
        div_zero_s  = (md_operand_2 == {DATA_W{1'b0}});
        div_start_s = accept_s && md_is_div(md_op) && !div_zero_s;
    end

    hilo_divider #(
        .DATA_W     (DATA_W),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_divider (
        .clk       (clk),
        .rst       (rst),
        .cancel    (md_cancel),
        .start     (div_start_s),
        .dividend  (mag1_s),
        .divisor   (mag2_s),
        .quotient  (div_quo_s),
        .remainder (div_rem_s),
        .done      (div_done_s)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; cancel returns to IDLE from anywhere
    always_comb begin
        state_nxt_s = state_r;
        if (md_cancel) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!md_start) begin
                        state_nxt_s = ST_IDLE;
                    end else if (!md_is_div(md_op)) begin
                        state_nxt_s = ST_MUL;
                    end else if (div_zero_s) begin
                        state_nxt_s = ST_SIGN;
                    end else begin
                        state_nxt_s = ST_DIV;
                    end
                end
                ST_MUL: state_nxt_s = ST_SIGN;
                ST_DIV: begin
                    if (div_done_s) begin
                        state_nxt_s = ST_SIGN;
                    end else begin
                        state_nxt_s = ST_DIV;
                    end
                end
                ST_SIGN: state_nxt_s = ST_IDLE;
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // Stall while an accepted operation is still computing (not in SIGN)
    always_comb begin
        stall_req = 1'b0;
        if (!rst || md_cancel) begin
            stall_req = 1'b0;
        end else begin
            stall_req = accept_s || (state_r == ST_MUL) || (state_r == ST_DIV);
        end
    end

    // Full-width magnitude product of the latched operands
    always_comb begin
        product_s = {{DATA_W{1'b0}}, mag1_r} * {{DATA_W{1'b0}}, mag2_r};
    end

    // Operand latch, sign flags, and result staging for MUL / divide-by-zero
    always_ff @(posedge clk) begin
        if (!rst) begin
            mag1_r    <= {DATA_W{1'b0}};
            mag2_r    <= {DATA_W{1'b0}};
            res_hi_r  <= {DATA_W{1'b0}};
            res_lo_r  <= {DATA_W{1'b0}};
            neg_q_r   <= 1'b0;
            neg_r_r   <= 1'b0;
            src_div_r <= 1'b0;
        end else if (accept_s) begin
            mag1_r <= mag1_s;
            mag2_r <= mag2_s;
            if (md_is_div(md_op) && div_zero_s) begin
                // Divide by zero: raw dividend to HI, all-ones to LO, no sign fixup
                res_hi_r  <= md_operand_1;
                res_lo_r  <= {DATA_W{1'b1}};
                neg_q_r   <= 1'b0;
                neg_r_r   <= 1'b0;
                src_div_r <= 1'b0;
            end else begin
                neg_q_r   <= sign1_s ^ sign2_s;
                neg_r_r   <= sign1_s;
                src_div_r <= md_is_div(md_op);
            end
        end else if (state_r == ST_MUL) begin
            res_hi_r <= product_s[2*DATA_W-1:DATA_W];
            res_lo_r <= product_s[DATA_W-1:0];
        end
    end

    // Sign correction and commit enable for the SIGN cycle
    always_comb begin
        commit_en_s = 1'b0;
        prod_mag_s  = {res_hi_r, res_lo_r};
        prod_fix_s  = prod_mag_s;
        commit_hi_s = {DATA_W{1'b0}};
        commit_lo_s = {DATA_W{1'b0}};
        if ((state_r == ST_SIGN) && !md_cancel) begin
            commit_en_s = 1'b1;
        end else begin
            commit_en_s = 1'b0;
        end
        if (src_div_r) begin
            if (neg_q_r) begin
                commit_lo_s = -div_quo_s;
            end else begin
                commit_lo_s = div_quo_s;
            end
            if (neg_r_r) begin
                commit_hi_s = -div_rem_s;
            end else begin
                commit_hi_s = div_rem_s;
            end
        end else begin
            if (neg_q_r) begin
                prod_fix_s = -prod_mag_s;
            end else begin
                prod_fix_s = prod_mag_s;
            end
            commit_hi_s = prod_fix_s[2*DATA_W-1:DATA_W];
            commit_lo_s = prod_fix_s[DATA_W-1:0];
        end
    end

    // Architectural HI/LO: reset, then engine commit, then direct write
    always_ff @(posedge clk) begin
        if (!rst) begin
            hi_r <= {DATA_W{1'b0}};
            lo_r <= {DATA_W{1'b0}};
        end else if (commit_en_s) begin
            hi_r <= commit_hi_s;
            lo_r <= commit_lo_s;
        end else if (hilo_write_en) begin
            hi_r <= hi_in;
            lo_r <= lo_in;
        end
    end

`ifdef HILO_READ_BYPASS_EN
    // Forward same-cycle write data so MFHI/MFLO see it without waiting
    always_comb begin
        hi_out = hi_r;
        lo_out = lo_r;
        if (commit_en_s) begin
            hi_out = commit_hi_s;
            lo_out = commit_lo_s;
        end else if (hilo_write_en) begin
            hi_out = hi_in;
            lo_out = lo_in;
        end else begin
            hi_out = hi_r;
            lo_out = lo_r;
        end
    end
`else
    assign hi_out = hi_r;
    assign lo_out = lo_r;
`endif

endmodule

// File: doc/hilo_unit.md
Name: hilo_unit

Overview:
HI/LO register file and multiply/divide engine that receives the HI/LO writes produced by the EX stage and serves the HI/LO read values back to it. It handles MTHI/MTLO-style direct writes and performs MULT, MULTU, DIV and DIVU. Multiply/divide runs as a multi-cycle operation, with a stall request back to the pipeline. It sits beside EX and is clocked with the core.

Parameters:
DATA_W, 32, width of HI, LO and operands
DIV_CYCLES, 32, iteration count of the restoring divider (must equal DATA_W)

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active-low (0 = reset)
hilo_write_en  in  1  direct write strobe from EX
hi_in  in  DATA_W  HI value to write (EX supplies the current HI when only LO changes)
lo_in  in  DATA_W  LO value to write
md_start  in  1  start a multiply/divide; held stable while stall_req=1
md_op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
md_operand_1  in  DATA_W  rs (multiplicand/dividend)
md_operand_2  in  DATA_W  rt (multiplier/divisor)
md_cancel  in  1  flush: abort any operation in flight, no HI/LO write
stall_req  out  1  hold EX and earlier stages
hi_out  out  DATA_W  current HI value to EX
lo_out  out  DATA_W  current LO value to EX

Behaviour:
- Reset (rst=0 at a clk edge): HI=0, LO=0, state=IDLE; stall_req=0 in the reset cycle; hi_out/lo_out read 0 after the edge.
- States: IDLE, MUL, DIV, SIGN.
- IDLE, md_start=1, md_cancel=0:
  - Latch operand magnitudes; for MULT/DIV, take the absolute value of each operand.
  - Latch the result sign flags: product/quotient negative = sign1 XOR sign2; remainder sign = sign1. Unsigned ops have both flags 0.
  - MULT/MULTU -> MUL. DIV/DIVU with operand_2≠0 -> DIV with counter=0.
  - DIV/DIVU with operand_2=0 -> SIGN with result preset HI=md_operand_1 (raw), LO=0xFFFFFFFF, sign flags cleared.
- MUL: one cycle; 64-bit magnitude product registered -> SIGN.
- DIV: one restoring step per cycle on {remainder, quotient}; after DIV_CYCLES steps -> SIGN.
- SIGN: apply sign correction; HI=remainder or product[63:32], LO=quotient or product[31:0]. Commit at the clk edge, then -> IDLE.
- Signed overflow case -2^31/-1: LO=0x80000000, HI=0.
- stall_req = (IDLE & md_start & ~md_cancel) | MUL | DIV. It is 0 in SIGN, so the instruction leaves EX on the commit edge.
- Latency, start cycle to HI/LO update: MULT 3 cycles (stall 2), DIV 34 cycles (stall 33), divide-by-zero 2 cycles (stall 1).
- md_start is ignored outside IDLE.
- md_cancel=1 in any state -> IDLE next edge with no write; stall_req=0 in that cycle.
- Direct write: hilo_write_en=1 -> HI=hi_in, LO=lo_in at the edge.
- Same-edge conflict: SIGN commit has priority over hilo_write_en. rst=0 has priority over both.
- Reads: hi_out/lo_out show registered HI/LO (bypass behaviour under Optional Feature).

Optional Feature:
HILO_READ_BYPASS_EN
- Defined: hi_out/lo_out combinationally forward the value being written this cycle, in priority order commit data, then hi_in/lo_in, then registers. MFHI sees a same-cycle write.
- Undefined: hi_out/lo_out are pure register outputs; the pipeline must forward externally.

Decomposition:
- The shared define header carries MD_OP_MULT/MULTU/DIV/DIVU encodings, hilo_unit state encodings and DATA_BUS width.
- One sub-module, hilo_divider, holds the iterative restoring divider core. Its interface is start/dividend/divisor in, quotient/remainder/done out, plus cancel.
- Sign handling and the MUL path stay in hilo_unit.

Test Plan:
1. MULT -3 (0xFFFFFFFD) x 5 -> stall_req 1 for 2 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFF1 after cycle 3.
2. DIVU 100/7 -> stall_req 1 for 33 cycles; LO=14, HI=2. DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
3. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU 9/0 -> after 2 cycles HI=9, LO=0xFFFFFFFF.
4. DIV started, md_cancel at cycle 10 -> stall_req drops that cycle; HI/LO unchanged; next md_start (MULTU 2x3) gives HI=0, LO=6.
5. hilo_write_en with hi_in=0x1234, lo_in=old LO -> HI=0x1234 next cycle. With HILO_READ_BYPASS_EN, hi_out=0x1234 in the same cycle.
6. Force hilo_write_en=1 in the SIGN cycle of MULTU 0xFFFFFFFF x 2 -> commit wins: HI=1, LO=0xFFFFFFFE. Apply rst=0 mid-DIV -> HI=LO=0, stall_req=0.
